// File: rtl/dmem_responder.sv
// Slow word-addressed data RAM for the CPU31 datapath.
// Stalls the CPU for LATENCY+1 cycles per access and flags bad addresses.
module dmem_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_ena,
    input  logic        dm_wena,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        dm_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [32:0] SPAN = 33'd4 << ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              wena_q;
    logic [31:0]       off;
    logic              bad;
    logic              fire;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];

    assign off  = addr_q - BASE_ADDR;
    assign bad  = (addr_q[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
    assign idx  = off[ADDR_W+1:2];
    assign fire = (state == WAIT) && dm_ena && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (dm_ena) state_nxt = WAIT;
            WAIT:    if (!dm_ena) state_nxt = IDLE;
                     else if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dm_stall = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    dm_stall = dm_ena;
                WAIT:    dm_stall = 1'b1;
                default: dm_stall = 1'b0;
            endcase
        end
    end

    // Request latch, wait counter and completion results
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wena_q   <= 1'b0;
            dm_rdata <= 32'd0;
            dm_err   <= 1'b0;
        end else begin
            dm_err <= 1'b0;
            if (state == IDLE && dm_ena) begin
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                wena_q  <= dm_wena;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT && dm_ena) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (bad) begin
                    dm_rdata <= 32'd0;
                    dm_err   <= 1'b1;
                end else if (!wena_q) begin
                    dm_rdata <= ram[idx];
                end
            end
        end
    end

    // RAM has no reset; a store only lands on its completion edge
    always_ff @(posedge clk) begin
        if (!rst && fire && wena_q && !bad)
            ram[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY=2 (u0) and LATENCY=1 (u1).
// Expected results are queued on issue and compared at the DONE cycle.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h10010000;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stalls;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena   [2];
    logic        wena  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        err   [2];

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sbq [$];
    logic [31:0] mdl  [2][1024];
    logic [31:0] last [2];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(BASE)) u0 (
        .clk(clk), .rst(rst),
        .dm_ena(ena[0]), .dm_wena(wena[0]),
        .dm_addr(addr[0]), .dm_wdata(wdata[0]),
        .dm_rdata(rdata[0]), .dm_stall(stall[0]), .dm_err(err[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(BASE)) u1 (
        .clk(clk), .rst(rst),
        .dm_ena(ena[1]), .dm_wena(wena[1]),
        .dm_addr(addr[1]), .dm_wdata(wdata[1]),
        .dm_rdata(rdata[1]), .dm_stall(stall[1]), .dm_err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One access on instance k; keep leaves dm_ena high for a back-to-back
    // follow-up, scr scrambles the inputs after they have been latched.
    task automatic access(input int k, input logic we,
                          input logic [31:0] a, input logic [31:0] d,
                          input string tag, input bit keep, input bit scr);
        exp_t        e;
        logic [31:0] off;
        bit          bad;
        int          idx;
        int          n;
        off = a - BASE;
        bad = (a[1:0] != 2'b00) || (off >= 32'h1000);
        idx = int'(off[11:2]);
        if (bad)      last[k] = 32'd0;
        else if (!we) last[k] = mdl[k][idx];
        else          mdl[k][idx] = d;
        e.rd     = last[k];
        e.err    = bad;
        e.stalls = (k == 0) ? 3 : 2;
        e.tag    = tag;
        sbq.push_back(e);
        @(negedge clk);
        ena[k]   = 1'b1;
        wena[k]  = we;
        addr[k]  = a;
        wdata[k] = d;
        #1;
        n = 0;
        while (stall[k] === 1'b1 && n < 40) begin
            n++;
            if (scr && n == 2) begin
                addr[k]  = ~a;
                wdata[k] = ~d;
                wena[k]  = ~we;
            end
            @(negedge clk);
            #1;
        end
        e = sbq.pop_front();
        chk({e.tag, "/stalls"}, n, e.stalls);
        chk({e.tag, "/rdata"}, rdata[k], e.rd);
        chk({e.tag, "/err"}, {31'd0, err[k]}, {31'd0, e.err});
        if (!keep) ena[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ena[k]   = 1'b1;
            wena[k]  = 1'b0;
            addr[k]  = BASE;
            wdata[k] = 32'd0;
            last[k]  = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst/stall", {31'd0, stall[k]}, 32'd0);
            chk("rst/rdata", rdata[k], 32'd0);
            chk("rst/err", {31'd0, err[k]}, 32'd0);
        end
        @(negedge clk);
        rst    = 1'b0;
        ena[0] = 1'b0;
        ena[1] = 1'b0;

        access(0, 1'b1, 32'h10010008, 32'hDEADBEEF, "st08", 0, 0);
        access(0, 1'b0, 32'h10010008, 32'h0, "ld08", 0, 0);
        access(0, 1'b1, 32'h10010000, 32'hA5A50000, "st00", 0, 0);
        access(0, 1'b1, 32'h10010004, 32'h44444444, "st04", 0, 1);
        access(0, 1'b0, 32'h10010004, 32'h0, "ld04", 0, 0);

        access(0, 1'b0, 32'h10010006, 32'h0, "mis", 0, 0);
        @(negedge clk);
        #1;
        chk("mis/errpulse", {31'd0, err[0]}, 32'd0);
        access(0, 1'b0, 32'h10010004, 32'h0, "ld04b", 0, 0);

        access(0, 1'b1, 32'h10011000, 32'h00000BAD, "oor", 0, 0);
        access(0, 1'b0, 32'h10010000, 32'h0, "ld00", 0, 0);

        access(0, 1'b1, 32'h10010010, 32'h11111111, "st10", 0, 0);
        @(negedge clk);
        ena[0]   = 1'b1;
        wena[0]  = 1'b1;
        addr[0]  = 32'h10010010;
        wdata[0] = 32'h12345678;
        @(negedge clk);
        chk("abort/wait", {31'd0, stall[0]}, 32'd1);
        ena[0] = 1'b0;
        @(negedge clk);
        chk("abort/idle", {31'd0, stall[0]}, 32'd0);
        chk("abort/err", {31'd0, err[0]}, 32'd0);
        access(0, 1'b0, 32'h10010010, 32'h0, "ld10", 0, 0);

        access(0, 1'b0, 32'h10010008, 32'h0, "ld08b", 0, 0);
        @(negedge clk);
        ena[0]   = 1'b1;
        wena[0]  = 1'b1;
        addr[0]  = 32'h10010008;
        wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw/stall", {31'd0, stall[0]}, 32'd0);
        @(negedge clk);
        #1;
        chk("rstw/rdata", rdata[0], 32'd0);
        chk("rstw/err", {31'd0, err[0]}, 32'd0);
        chk("rstw/stall2", {31'd0, stall[0]}, 32'd0);
        rst     = 1'b0;
        ena[0]  = 1'b0;
        last[0] = 32'd0;
        last[1] = 32'd0;
        access(0, 1'b0, 32'h10010008, 32'h0, "rstw/ld", 0, 0);

        access(0, 1'b1, 32'h10010020, 32'h0A0A0A0A, "st20", 0, 0);
        access(0, 1'b1, 32'h10010024, 32'h0B0B0B0B, "st24", 0, 0);
        access(0, 1'b0, 32'h10010020, 32'h0, "b2b/A", 1, 0);
        access(0, 1'b0, 32'h10010024, 32'h0, "b2b/B", 0, 0);

        access(1, 1'b1, 32'h10010100, 32'h13572468, "l1/stA", 0, 0);
        access(1, 1'b1, 32'h10010FFC, 32'h89ABCDEF, "l1/stB", 0, 0);
        access(1, 1'b0, 32'h10010100, 32'h0, "l1/b2bA", 1, 0);
        access(1, 1'b0, 32'h10010FFC, 32'h0, "l1/b2bB", 0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU31 datapath; serves the DM_ena/DM_wena requests issued by the instruction controller.
- Models a slow, word-addressed data RAM with a fixed access latency.
- Holds the CPU through dm_stall until each load or store completes, and flags misaligned or out-of-range addresses.
- Sits between the top-level datapath (ALU_r as address, RF_rdata2 as store data) and the controller's DM_data_out input.

Parameters:
ADDR_W, 10, word-index width; the RAM holds 2^ADDR_W 32-bit words.
LATENCY, 2, wait cycles per access; legal range 1..15.
BASE_ADDR, 32'h10010000, byte address mapped to word 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
dm_ena  input  1  access request (load or store), held by the CPU until dm_stall falls.
dm_wena  input  1  1 = store, 0 = load; meaningful only when dm_ena=1.
dm_addr  input  32  byte address (ALU_r).
dm_wdata  input  32  store data (RF_rdata2).
dm_rdata  output  32  load data (DM_data_out), registered.
dm_stall  output  1  1 = the CPU must not advance PC or write RF this cycle.
dm_err  output  1  one-cycle pulse: the completed access was misaligned or out of range.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE, cnt=0, dm_rdata=0, dm_err=0.
  - dm_stall=0 while rst=1.
  - RAM contents are NOT cleared by reset.
- Address check on the latched request:
  - off = addr - BASE_ADDR (32-bit, wraps).
  - Misaligned if addr[1:0] != 0.
  - Out of range if off >= 4*2^ADDR_W.
  - Word index = off[ADDR_W+1:2].
- States: IDLE, WAIT, DONE.
- IDLE:
  - dm_stall = dm_ena.
  - If dm_ena=1: latch addr, wdata and wena; cnt <= LATENCY-1; go to WAIT.
- WAIT:
  - dm_stall=1.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0, on that edge:
    - valid store: RAM[idx] <= wdata.
    - valid load: dm_rdata <= RAM[idx].
    - bad address: no write; dm_rdata <= 0; dm_err <= 1.
    - go to DONE.
- DONE:
  - dm_stall=0 and dm_rdata is valid.
  - dm_err is high only in DONE and cleared on exit.
  - Next edge: go to IDLE. The CPU advances on this same edge.
  - dm_rdata holds its value until the next completed load or reset.
- Latency:
  - The request is seen in cycle 0; dm_stall is high for cycles 0..LATENCY and low in cycle LATENCY+1.
  - Stall cycles per access = LATENCY+1.
- Back-to-back accesses: if dm_ena is high in the IDLE cycle after DONE, a new transaction starts immediately. There is no idle gap beyond the DONE→IDLE cycle.
- Abort:
  - If dm_ena=0 while in WAIT, return to IDLE next edge with no RAM write and no dm_err.
  - If dm_ena=0 in DONE, the normal DONE→IDLE exit applies.
- Input changes mid-access: dm_addr, dm_wdata and dm_wena changes after latching are ignored. Only latched values are used.
- Reset mid-operation: rst wins over every transition. A pending store is discarded and the RAM is unmodified.
- Loads never modify the RAM. A store leaves dm_rdata unchanged.

Test Plan:
- Reset then store and load, LATENCY=2:
  - Store 32'hDEADBEEF to 32'h10010008: dm_stall high exactly 3 cycles.
  - Load of the same address: dm_rdata=32'hDEADBEEF in the DONE cycle, dm_err=0.
- Misaligned load: dm_addr=32'h10010006 → 3 stall cycles, dm_rdata=0, dm_err pulses exactly 1 cycle, RAM unchanged.
- Out of range, ADDR_W=10:
  - Store to 32'h10011000 → dm_err=1 and no write.
  - A load of 32'h10010000 returns its prior value.
- Abort: store 32'h12345678 to 32'h10010010, drop dm_ena in the first WAIT cycle → IDLE next cycle; a later load of that address returns the old value.
- Reset mid-WAIT: rst=1 during a store → dm_stall=0, dm_rdata=0, dm_err=0; the store target is unchanged.
- Back-to-back: load A then load B with dm_ena held high continuously → two 3-cycle stalls separated by one DONE cycle each, correct data for A and B. Repeat with LATENCY=1: 2 stall cycles per access.
